// File: rtl/ex_seq_ctrl.sv
// EX-stage sequencing controller: EMPTY/RUN/FULL FSM that holds multi-beat ops in EX.
// Define EX_SEQ_PERF_EN to build the RUN and backpressure performance counters.

module ex_seq_ctrl #(
    parameter int BEAT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_valid,
    input  logic              ME_ready,
    input  logic              flush,
    input  logic              in_multi,
    input  logic [BEAT_W-1:0] in_beats,
    input  logic              unit_stall,
    output logic              valid,
    output logic              ready,
    output logic              busy,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              unit_start,
    output logic              unit_step,
    output logic              res_load,
    output logic [31:0]       perf_run,
    output logic [31:0]       perf_bp
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_RUN   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
    localparam logic [BEAT_W-1:0] BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
    logic [BEAT_W-1:0] beats_q, beats_d;

    logic is_empty_s;
    logic is_run_s;
    logic is_full_s;
    logic ready_s;
    logic accept_s;
    logic multi_s;
    logic last_s;
    logic step_s;
    logic start_s;
    logic load_s;

    // State decode; the unused encoding decodes to nothing so it can neither accept nor emit.
    always_comb begin
        is_empty_s = 1'b0;
        is_run_s   = 1'b0;
        is_full_s  = 1'b0;
        case (state_q)
            ST_EMPTY: is_empty_s = 1'b1;
            ST_RUN:   is_run_s   = 1'b1;
            ST_FULL:  is_full_s  = 1'b1;
            default:  is_empty_s = 1'b0;
        endcase
    end

    // Handshake and iterative-unit strobes; flush suppresses every side effect.
    always_comb begin
        ready_s  = is_empty_s | (is_full_s & ME_ready);
        accept_s = ready_s & ID_valid & ~flush;
        multi_s  = in_multi & (in_beats > BEAT_ONE);
        last_s   = (beat_idx_q == (beats_q - BEAT_ONE));
        step_s   = is_run_s & ~unit_stall & ~flush;
        start_s  = step_s & (beat_idx_q == BEAT_ZERO);
        load_s   = (accept_s & ~multi_s) | (step_s & last_s);
    end

    // Next-state logic; FULL with ME_ready makes the same accept decision as EMPTY.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        beats_d    = beats_q;
        if (flush) begin
            state_d    = ST_EMPTY;
            beat_idx_d = BEAT_ZERO;
        end else begin
            case (state_q)
                ST_EMPTY, ST_FULL: begin
                    if (accept_s && multi_s) begin
                        state_d    = ST_RUN;
                        beat_idx_d = BEAT_ZERO;
                        beats_d    = in_beats;
                    end else if (accept_s) begin
                        state_d = ST_FULL;
                    end else if (is_full_s && ME_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (step_s && last_s) begin
                        state_d    = ST_FULL;
                        beat_idx_d = BEAT_ZERO;
                    end else if (step_s) begin
                        beat_idx_d = beat_idx_q + BEAT_ONE;
                    end else begin
                        beat_idx_d = beat_idx_q;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    beat_idx_d = BEAT_ZERO;
                    beats_d    = BEAT_ZERO;
                end
            endcase
        end
    end

    // FSM state, beat index and latched beat count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            beat_idx_q <= BEAT_ZERO;
            beats_q    <= BEAT_ZERO;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            beats_q    <= beats_d;
        end
    end

`ifdef EX_SEQ_PERF_EN
    logic [31:0] perf_run_q, perf_run_d;
    logic [31:0] perf_bp_q, perf_bp_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        perf_run_d = perf_run_q;
        perf_bp_d  = perf_bp_q;
        if (is_run_s) begin
            perf_run_d = perf_run_q + 32'd1;
        end else begin
            perf_run_d = perf_run_q;
        end
        if (is_full_s && !ME_ready) begin
            perf_bp_d = perf_bp_q + 32'd1;
        end else begin
            perf_bp_d = perf_bp_q;
        end
    end

    // Performance counter registers, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_run_q <= 32'd0;
            perf_bp_q  <= 32'd0;
        end else begin
            perf_run_q <= perf_run_d;
            perf_bp_q  <= perf_bp_d;
        end
    end

    assign perf_run = perf_run_q;
    assign perf_bp  = perf_bp_q;
`else
    assign perf_run = 32'd0;
    assign perf_bp  = 32'd0;
`endif

    assign valid      = is_full_s;
    assign busy       = is_run_s;
    assign ready      = ready_s;
    assign beat_idx   = beat_idx_q;
    assign unit_start = start_s;
    assign unit_step  = step_s;
    assign res_load   = load_s;

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Scoreboard bench for ex_seq_ctrl: directed per-cycle vectors with hand-computed expectations.
// Perf counter expectations follow EX_SEQ_PERF_EN (zero when undefined).

module tb_ex_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        ID_valid;
    logic        ME_ready;
    logic        flush;
    logic        in_multi;
    logic [3:0]  in_beats;
    logic        unit_stall;
    logic        valid;
    logic        ready;
    logic        busy;
    logic [3:0]  beat_idx;
    logic        unit_start;
    logic        unit_step;
    logic        res_load;
    logic [31:0] perf_run;
    logic [31:0] perf_bp;

    ex_seq_ctrl #(.BEAT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ID_valid   (ID_valid),
        .ME_ready   (ME_ready),
        .flush      (flush),
        .in_multi   (in_multi),
        .in_beats   (in_beats),
        .unit_stall (unit_stall),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .beat_idx   (beat_idx),
        .unit_start (unit_start),
        .unit_step  (unit_step),
        .res_load   (res_load),
        .perf_run   (perf_run),
        .perf_bp    (perf_bp)
    );

    typedef struct packed {
        logic [7:0]  sec;
        logic [15:0] n;
        logic        ev;
        logic        er;
        logic        eb;
        logic [3:0]  ei;
        logic        es;
        logic        ep;
        logic        el;
        logic [31:0] prun;
        logic [31:0] pbp;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          issued = 0;
    logic [31:0] run_cnt = 32'd0;
    logic [31:0] bp_cnt = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string sec_name(input logic [7:0] s);
        case (s)
            8'd0:    return "idle";
            8'd1:    return "single_stream";
            8'd2:    return "multi_stall";
            8'd3:    return "backpressure";
            8'd4:    return "flush_run";
            8'd5:    return "flush_full";
            8'd6:    return "flush_stall";
            8'd7:    return "degenerate";
            8'd8:    return "reset_run";
            default: return "other";
        endcase
    endfunction

    // Monitor: every cycle the DUT presents outputs, pop the expected record and compare.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if ({valid, ready, busy, beat_idx, unit_start, unit_step, res_load, perf_run, perf_bp} !==
                {e.ev, e.er, e.eb, e.ei, e.es, e.ep, e.el, e.prun, e.pbp}) begin
                miscompares++;
                $display("FAIL vec %0d %s: got v=%b r=%b busy=%b idx=%0d start=%b step=%b load=%b run=%0d bp=%0d, want v=%b r=%b busy=%b idx=%0d start=%b step=%b load=%b run=%0d bp=%0d",
                         e.n, sec_name(e.sec), valid, ready, busy, beat_idx, unit_start, unit_step,
                         res_load, perf_run, perf_bp, e.ev, e.er, e.eb, e.ei, e.es, e.ep, e.el,
                         e.prun, e.pbp);
            end
        end
    end

    task automatic push_exp(input logic ev, er, eb, input logic [3:0] ei,
                            input logic es, ep, el, input int sec);
        exp_t e;
        e.sec  = sec[7:0];
        e.n    = issued[15:0];
        e.ev   = ev;
        e.er   = er;
        e.eb   = eb;
        e.ei   = ei;
        e.es   = es;
        e.ep   = ep;
        e.el   = el;
`ifdef EX_SEQ_PERF_EN
        e.prun = run_cnt;
        e.pbp  = bp_cnt;
`else
        e.prun = 32'd0;
        e.pbp  = 32'd0;
`endif
        sb.push_back(e);
        issued++;
    endtask

    // One cycle: drive inputs, then queue the outputs expected for this cycle.
    task automatic step(input logic iv, mr, fl, mu, input logic [3:0] bt, input logic st,
                        input logic ev, er, eb, input logic [3:0] ei,
                        input logic es, ep, el, input int sec);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        ID_valid   = iv;
        ME_ready   = mr;
        flush      = fl;
        in_multi   = mu;
        in_beats   = bt;
        unit_stall = st;
        push_exp(ev, er, eb, ei, es, ep, el, sec);
        if (eb) run_cnt = run_cnt + 32'd1;
        if (ev && !mr) bp_cnt = bp_cnt + 32'd1;
    endtask

    task automatic idle(input int sec);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0,
             1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, sec);
    endtask

    // Assert rst mid-cycle; outputs must already be back at reset values.
    task automatic reset_step(input int sec);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        ID_valid   = 1'b0;
        ME_ready   = 1'b1;
        flush      = 1'b0;
        in_multi   = 1'b0;
        in_beats   = 4'd0;
        unit_stall = 1'b0;
        run_cnt    = 32'd0;
        bp_cnt     = 32'd0;
        push_exp(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, sec);
    endtask

    initial begin
        rst        = 1'b1;
        ID_valid   = 1'b0;
        ME_ready   = 1'b1;
        flush      = 1'b0;
        in_multi   = 1'b0;
        in_beats   = 4'd0;
        unit_stall = 1'b0;
        repeat (2) @(posedge clk);

        //   iv    mr    fl    mu    bt    st     v     r     busy  idx   start step  load
        for (int i = 0; i < 5; i++) idle(0);

        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, (i > 0), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1);
        idle(1);

        // 4-beat op, stall in the second RUN cycle; ID keeps offering to show ready=0.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2);
        idle(2);

        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3);
        idle(3);

        // 8-beat op flushed at beat 3.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4);
        idle(4);

        // Flush while FULL with ME_ready=1 and ID offering: no accept, result dropped.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 5);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5);
        idle(5);

        // Flush coinciding with a unit stall.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 6);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 6);
        idle(6);

        // in_beats 0 and 1 act single-cycle; 2 is the smallest RUN, entered back-to-back from FULL.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 7);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 7);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 7);
        idle(7);

        // rst mid-RUN: immediate return to reset values.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 8);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8);
        reset_step(8);
        idle(8);
        idle(8);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never compared, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_seq_ctrl.md
Name: ex_seq_ctrl

Overview:
- EX-stage sequencing controller. Replaces the simple one-deep valid/ready register with a 3-state FSM that can hold an instruction in EX for several beats.
- Multi-beat ops (512-bit matrix, iterative FP) drive a shared iterative unit beat by beat before the result is offered to ME.
- Drives the stage handshake (ready to ID, valid to ME), plus beat/step controls and a result-latch enable for the EX output registers.
- Sits between the ID and ME handshakes; instruction/operand latches load on `ready`, result latches load on `res_load`.

Parameters:
- BEAT_W, 4, width of beat count and beat index; max beats = 2^BEAT_W-1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ID_valid  in  1  ID offers an instruction
- ME_ready  in  1  ME can accept this cycle
- flush  in  1  synchronous kill of EX contents (redirect)
- in_multi  in  1  offered instruction is multi-beat
- in_beats  in  BEAT_W  beat count of offered instruction
- unit_stall  in  1  iterative unit cannot advance this cycle
- valid  out  1  EX holds a finished result for ME
- ready  out  1  EX accepts from ID this cycle (combinational)
- busy  out  1  FSM in RUN
- beat_idx  out  BEAT_W  current beat, 0-based
- unit_start  out  1  first-beat strobe to iterative unit
- unit_step  out  1  advance strobe to iterative unit
- res_load  out  1  load enable for EX result registers
- perf_run  out  32  RUN cycle count (optional feature)
- perf_bp  out  32  FULL && !ME_ready cycle count (optional feature)

Behaviour:
- Reset (async, rst=1): state=EMPTY, valid=0, busy=0, beat_idx=0, beats_q=0. Perf counters reset to 0.
- States: EMPTY, RUN, FULL. Outputs: valid=(FULL), busy=(RUN).
- ready = (EMPTY) | (FULL & ME_ready). ready=0 in RUN.
- accept = ready & ID_valid & !flush.
- multi = in_multi & (in_beats >= 2). Sampled only on accept.
- in_beats 0 or 1 is treated as a single-cycle op.
- EMPTY:
  - accept & multi → RUN; beat_idx<=0; beats_q<=in_beats.
  - accept & !multi → FULL.
  - else stay.
- RUN:
  - unit_start = (beat_idx==0) & !unit_stall.
  - unit_step = !unit_stall.
  - last = (beat_idx == beats_q-1).
  - unit_step & !last → beat_idx+1.
  - unit_step & last → FULL, beat_idx<=0.
  - unit_stall → hold all state.
- FULL:
  - ME_ready & accept → same decision as EMPTY (back-to-back, no bubble).
  - ME_ready & !accept → EMPTY.
  - !ME_ready → hold; valid stays 1.
- res_load (combinational) = (accept & !multi) | (RUN & unit_step & last). Asserted exactly on the edge where the FSM enters FULL.
- Latency: single-cycle op has valid 1 cycle after accept. N-beat op with no stalls has valid N+1 cycles after accept.
- flush (priority over all):
  - next state EMPTY, beat_idx<=0, no accept this cycle.
  - res_load=0, unit_start=0, unit_step=0.
  - Aborts RUN mid-operation; drops a FULL result even if ME_ready=1. ME must ignore valid in the flush cycle.
- Simultaneous unit_stall & flush: flush wins.
- rst asserted mid-RUN: immediate return to reset values, no completion pulse.

Optional Feature:
- Macro: EX_SEQ_PERF_EN.
- Defined:
  - perf_run increments every RUN cycle.
  - perf_bp increments every FULL & !ME_ready cycle.
  - Both 32-bit, wrap modulo 2^32, cleared only by rst.
- Undefined: perf_run=perf_bp=0 constant, no counter flops.

Test Plan:
- Reset/idle: after rst, ID_valid=0 for 5 cycles → valid=0, ready=1, busy=0, beat_idx=0.
- Single-cycle stream: ID_valid=1, in_multi=0, ME_ready=1 for 4 cycles → res_load=1 each cycle, valid=1 from cycle 1, ready stays 1 (no bubble).
- Multi-beat with stall:
  - Accept in_multi=1, in_beats=4, ME_ready=1, unit_stall=1 in 2nd RUN cycle.
  - Required: unit_start in 1st RUN cycle; beat_idx 0,1,1,2,3; ready=0 throughout RUN.
  - res_load on beat 3; valid 6 cycles after accept.
- Backpressure: valid=1, ME_ready=0 for 3 cycles, ID_valid=1 → ready=0, no accept, valid held.
  - ME_ready=1 → accept next instruction same cycle.
- Flush mid-RUN: in_beats=8, flush at beat_idx=3 → next cycle EMPTY, valid=0, beat_idx=0, no res_load.
  - Flush while FULL with ME_ready=1 → EMPTY, no accept.
- Degenerate beats: in_multi=1, in_beats=0 and =1 → behave as single-cycle (FULL next cycle, busy never 1).
  - With EX_SEQ_PERF_EN: 4-beat unstalled op → perf_run=4; 3 backpressure cycles → perf_bp=3.
